// File: rtl/trace_capture_packetizer.sv
// Frames a raw 32-bit trace sample stream into Avalon-ST packets:
// a header beat, 0..PKT_WORDS payload beats, then a trailer beat carrying the word count.
module trace_capture_packetizer #(
  parameter int          PKT_WORDS = 64,
  parameter logic [7:0]  HDR_ID    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty,
  output logic [15:0] pkt_count,
  output logic [7:0]  seq
);

  typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TRAILER} state_e;

  localparam logic [15:0] PKT_W = 16'(PKT_WORDS);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  seq_q, seq_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;
  logic [1:0]  out_empty_q, out_empty_d;

  logic        adv;
  logic        accept;
  logic [15:0] cnt_inc;

  // The single output register stage moves whenever it is empty or being drained.
  assign adv      = out_ready | ~out_valid_q;
  assign in_ready = (state_q == S_PAYLOAD) && adv;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seq_d       = seq_q;
    pkt_count_d = pkt_count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    cnt_inc     = cnt_q + {15'd0, accept};

    if (adv) begin
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      out_empty_d = 2'd0;
      case (state_q)
        S_IDLE: begin
          // The sample that opens the packet is only consumed once PAYLOAD is entered.
          if (enable && in_valid) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b1;
            out_data_d  = {HDR_ID, seq_q, PKT_W};
            cnt_d       = 16'd0;
            state_d     = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            cnt_d       = cnt_inc;
          end
          if (cnt_inc == PKT_W || flush || !enable)
            state_d = S_TRAILER;
        end
        S_TRAILER: begin
          out_valid_d = 1'b1;
          out_eop_d   = 1'b1;
          out_empty_d = 2'd2;
          out_data_d  = {cnt_q, 16'h0000};
          seq_d       = seq_q + 8'd1;
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      seq_q       <= 8'd0;
      pkt_count_q <= 16'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'd0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seq_q       <= seq_d;
      pkt_count_q <= pkt_count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_empty         = out_empty_q;
  assign pkt_count         = pkt_count_q;
  assign seq               = seq_q;

endmodule

// File: tb/tb_trace_capture_packetizer.sv
// Directed bench for trace_capture_packetizer: PKT_WORDS=4 main instance, PKT_WORDS=1 instance for seq wrap.
module tb_trace_capture_packetizer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic        out_ready;
  logic        out_valid, out_sop, out_eop;
  logic [31:0] out_data;
  logic [1:0]  out_empty;
  logic [15:0] pkt_count;
  logic [7:0]  seq;

  logic        rst1_n = 1'b0, en1 = 1'b0, vld1 = 1'b0, rdy1 = 1'b1;
  logic        in_ready1, out_valid1, sop1, eop1;
  logic [31:0] out_data1;
  logic [1:0]  empty1;
  logic [15:0] pkt_count1;
  logic [7:0]  seq1;

  logic bp = 1'b0, rdy_force = 1'b1, rnd_rdy = 1'b1;
  assign out_ready = bp ? rnd_rdy : rdy_force;

  int checks = 0, errors = 0;
  int exp_seq = 0;
  logic [63:0] got_q[$], exp_q[$];
  int viol = 0, hold_err = 0;
  logic stall_prev = 1'b0;
  logic [63:0] stall_beat = 64'd0;
  int hdr1_cnt = 0;
  logic [31:0] h255 = 32'd0, h256 = 32'd0, trl1 = 32'd0;
  logic [15:0] pc_at = 16'd0;
  logic trl_seen = 1'b0;

  always #5 clk = ~clk;

  trace_capture_packetizer #(.PKT_WORDS(4), .HDR_ID(8'hA5)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_sop), .out_endofpacket(out_eop), .out_empty(out_empty),
    .pkt_count(pkt_count), .seq(seq));

  trace_capture_packetizer #(.PKT_WORDS(1), .HDR_ID(8'hA5)) u_dut1 (
    .clk(clk), .reset_n(rst1_n), .enable(en1), .flush(1'b0),
    .in_valid(vld1), .in_data(32'h0000_1234), .in_ready(in_ready1),
    .out_ready(rdy1), .out_valid(out_valid1), .out_data(out_data1),
    .out_startofpacket(sop1), .out_endofpacket(eop1), .out_empty(empty1),
    .pkt_count(pkt_count1), .seq(seq1));

  function automatic logic [63:0] bt(input logic s, input logic e, input logic [1:0] emp,
                                     input logic [31:0] d);
    return {28'd0, s, e, emp, d};
  endfunction
  function automatic logic [63:0] hdr(input int s);
    return bt(1'b1, 1'b0, 2'd0, {8'hA5, 8'(s), 16'd4});
  endfunction
  function automatic logic [63:0] pay(input logic [31:0] w);
    return bt(1'b0, 1'b0, 2'd0, w);
  endfunction
  function automatic logic [63:0] trl(input int n);
    return bt(1'b0, 1'b1, 2'd2, {16'(n), 16'h0000});
  endfunction

  always @(posedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

  // Beat capture plus stall-hold and in_ready-under-stall monitors.
  always @(negedge clk) begin
    if (out_valid && out_ready)
      got_q.push_back(bt(out_sop, out_eop, out_empty, out_data));
    if (out_valid && !out_ready && in_ready) viol <= viol + 1;
    if (stall_prev && (bt(out_sop, out_eop, out_empty, out_data) != stall_beat || !out_valid))
      hold_err <= hold_err + 1;
    stall_prev <= out_valid && !out_ready;
    stall_beat <= bt(out_sop, out_eop, out_empty, out_data);
  end

  always @(negedge clk) begin
    if (out_valid1 && rdy1) begin
      if (sop1) begin
        if (hdr1_cnt == 255) h255 <= out_data1;
        if (hdr1_cnt == 256) begin h256 <= out_data1; pc_at <= pkt_count1; end
        hdr1_cnt <= hdr1_cnt + 1;
      end
      if (eop1 && !trl_seen) begin trl1 <= out_data1; trl_seen <= 1'b1; end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    logic acc;
    bit   done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
      done = acc;
    end
    if (!done) chk("push_timeout", 64'(w), 64'hFFFF_FFFF);
  endtask

  task automatic cmp_stream(input string tag);
    for (int i = 0; i < 800 && got_q.size() < exp_q.size(); i++) step();
    chk({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #3;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_sop_eop_empty", 64'({out_sop, out_eop, out_empty}), 64'd0);
    chk("rst_seq_pc", 64'({seq, pkt_count}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    step();

    // Full packet, then a second packet closed by flush after one word.
    enable = 1'b1;
    for (int w = 1; w <= 4; w++) push_word(32'(w));
    push_word(32'd5);
    in_valid = 1'b0;
    chk("full_pkt_count1", 64'(pkt_count), 64'd1);
    flush = 1'b1; step(); flush = 1'b0;
    exp_q.push_back(hdr(0));
    for (int w = 1; w <= 4; w++) exp_q.push_back(pay(32'(w)));
    exp_q.push_back(trl(4));
    exp_q.push_back(hdr(1)); exp_q.push_back(pay(32'd5)); exp_q.push_back(trl(1));
    exp_seq = 2;
    cmp_stream("full");
    chk("full_pkt_count2", 64'(pkt_count), 64'(exp_seq));
    chk("full_seq", 64'(seq), 64'(exp_seq));

    // Early flush after 3 words, with no sample pending.
    for (int w = 1; w <= 3; w++) push_word(32'(w));
    in_valid = 1'b0;
    flush = 1'b1; step(); flush = 1'b0;
    exp_q.push_back(hdr(exp_seq));
    for (int w = 1; w <= 3; w++) exp_q.push_back(pay(32'(w)));
    exp_q.push_back(trl(3));
    exp_seq++;
    cmp_stream("flush_idle");

    // Flush coincides with the accept of word 3: that word stays in the packet.
    push_word(32'd1); push_word(32'd2);
    flush = 1'b1; push_word(32'd3); flush = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back(hdr(exp_seq));
    for (int w = 1; w <= 3; w++) exp_q.push_back(pay(32'(w)));
    exp_q.push_back(trl(3));
    exp_seq++;
    cmp_stream("flush_acc");

    // Flush with zero payload words.
    in_valid = 1'b1; in_data = 32'hDEAD; step();
    in_valid = 1'b0; flush = 1'b1; step(); flush = 1'b0;
    exp_q.push_back(hdr(exp_seq)); exp_q.push_back(trl(0));
    exp_seq++;
    cmp_stream("flush_zero");

    // Flush held high: one payload word per packet.
    flush = 1'b1;
    push_word(32'd10); push_word(32'd11);
    in_valid = 1'b0; step(); flush = 1'b0;
    exp_q.push_back(hdr(exp_seq));     exp_q.push_back(pay(32'd10)); exp_q.push_back(trl(1));
    exp_q.push_back(hdr(exp_seq + 1)); exp_q.push_back(pay(32'd11)); exp_q.push_back(trl(1));
    exp_seq += 2;
    cmp_stream("flush_held");

    // Random back-pressure over 10 full packets.
    bp = 1'b1;
    for (int w = 0; w < 40; w++) push_word(32'h100 + 32'(w));
    in_valid = 1'b0;
    for (int p = 0; p < 10; p++) begin
      exp_q.push_back(hdr(exp_seq + p));
      for (int k = 0; k < 4; k++) exp_q.push_back(pay(32'h100 + 32'(p * 4 + k)));
      exp_q.push_back(trl(4));
    end
    exp_seq += 10;
    cmp_stream("bp");
    bp = 1'b0;
    step();
    chk("bp_in_ready_stall", 64'(viol), 64'd0);
    chk("bp_hold", 64'(hold_err), 64'd0);
    chk("bp_pkt_count", 64'(pkt_count), 64'(exp_seq));

    // Enable drop after 2 words; no new header while enable stays low.
    push_word(32'd1); push_word(32'd2);
    enable = 1'b0; in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = 32'd99;
    repeat (10) step();
    chk("en_low_valid", 64'(out_valid), 64'd0);
    chk("en_low_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    exp_q.push_back(hdr(exp_seq));
    exp_q.push_back(pay(32'd1)); exp_q.push_back(pay(32'd2));
    exp_q.push_back(trl(2));
    exp_seq++;
    cmp_stream("en_drop");
    enable = 1'b1;

    // Reset mid-payload abandons the packet; next header restarts at seq 0.
    push_word(32'd1); push_word(32'd2);
    in_valid = 1'b0;
    reset_n = 1'b0; #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data), 64'd0);
    chk("mid_rst_flags", 64'({out_sop, out_eop, out_empty}), 64'd0);
    chk("mid_rst_seq_pc", 64'({seq, pkt_count}), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk) reset_n = 1'b1;
    step();
    got_q.delete();
    in_valid = 1'b1; in_data = 32'd7; step();
    in_valid = 1'b0;
    chk("post_rst_hdr", bt(out_sop, out_eop, out_empty, out_data), hdr(0));
    flush = 1'b1; step(); flush = 1'b0;
    repeat (3) step();

    // Seq wrap with PKT_WORDS=1: 257 back-to-back packets.
    @(negedge clk) rst1_n = 1'b1;
    step();
    en1 = 1'b1; vld1 = 1'b1;
    for (int i = 0; i < 1200 && hdr1_cnt < 257; i++) step();
    vld1 = 1'b0;
    chk("wrap_hdr_count", 64'(hdr1_cnt >= 257), 64'd1);
    chk("wrap_hdr256", 64'(h255), 64'hA5FF_0001);
    chk("wrap_hdr257", 64'(h256), 64'hA500_0001);
    chk("wrap_pkt_count", 64'(pc_at), 64'd256);
    chk("wrap_trailer", 64'(trl1), 64'h0001_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
